// File: rtl/arm_run_monitor.sv
// Run controller and seven-segment debug display for the single-cycle ARM test system.
// Optional build macro RUN_MONITOR_BLANK_EN blanks leading-zero digits above digit 0.
module arm_run_monitor #(
    parameter int          NUM_DIGITS = 4,
    parameter int          DATA_WIDTH = 32,
    parameter int unsigned HALT_PC    = 100,
    parameter int unsigned PASS_ADDR  = 100,
    parameter int unsigned PASS_DATA  = 7,
    parameter int unsigned MAX_CYCLES = 1000
) (
    input  logic                    clk_50Mhz,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   pc,
    input  logic                    mem_write,
    input  logic [DATA_WIDTH-1:0]   data_adr,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic [DATA_WIDTH-1:0]   read_data,
    input  logic [1:0]              disp_sel,
    output logic                    cpu_en,
    output logic [2:0]              state,
    output logic [DATA_WIDTH-1:0]   cycle_count,
    output logic                    led_success,
    output logic                    led_fail,
    output logic                    halted,
    output logic [7*NUM_DIGITS-1:0] seg
);

    typedef enum logic [2:0] {
        S_HOLD = 3'd0,
        S_RUN  = 3'd1,
        S_PASS = 3'd2,
        S_FAIL = 3'd3,
        S_HALT = 3'd4
    } run_state_t;

    localparam logic [DATA_WIDTH-1:0] HALT_V    = DATA_WIDTH'(HALT_PC);
    localparam logic [DATA_WIDTH-1:0] ADDR_V    = DATA_WIDTH'(PASS_ADDR);
    localparam logic [DATA_WIDTH-1:0] DATA_V    = DATA_WIDTH'(PASS_DATA);
    localparam logic [DATA_WIDTH-1:0] TIMEOUT_V = DATA_WIDTH'(MAX_CYCLES - 1);
    localparam int BW = 4 * NUM_DIGITS;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    run_state_t state_q, state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HOLD: state_d = S_RUN;
            S_RUN: begin
                // Signature store outranks halt and timeout in the same cycle.
                if (mem_write && data_adr == ADDR_V && write_data == DATA_V) state_d = S_PASS;
                else if (mem_write && data_adr == ADDR_V)                    state_d = S_FAIL;
                else if (pc > HALT_V)                                        state_d = S_HALT;
                else if (cycle_count == TIMEOUT_V)                           state_d = S_FAIL;
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk_50Mhz or negedge reset) begin
        if (!reset) begin
            state_q     <= S_HOLD;
            cpu_en      <= 1'b0;
            cycle_count <= '0;
            led_success <= 1'b0;
            led_fail    <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cpu_en      <= (state_q == S_RUN) && (state_d == S_RUN || state_q == S_RUN);
            led_success <= (state_d == S_PASS);
            led_fail    <= (state_d == S_FAIL);
            halted      <= (state_d == S_PASS) || (state_d == S_FAIL) || (state_d == S_HALT);
            if (state_q == S_RUN) cycle_count <= cycle_count + DATA_WIDTH'(1);
        end
    end

    assign state = state_q;

    // Double-dabble converter: one LOAD cycle then DATA_WIDTH shift cycles.
    logic [CW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] val_sr, src_value;
    logic [BW-1:0]         bcd_sr, bcd_adj, bcd_next, digits_q;

    always_comb begin
        src_value = pc;
        case (disp_sel)
            2'd0: src_value = pc;
            2'd1: src_value = cycle_count;
            2'd2: src_value = read_data;
            default: src_value = {{(DATA_WIDTH-3){1'b0}}, state_q};
        endcase
    end

    always_comb begin
        bcd_adj = bcd_sr;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_sr[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
        end
        bcd_next = {bcd_adj[BW-2:0], val_sr[DATA_WIDTH-1]};
    end

    always_ff @(posedge clk_50Mhz or negedge reset) begin
        if (!reset) begin
            bit_cnt  <= '0;
            val_sr   <= '0;
            bcd_sr   <= '0;
            digits_q <= '0;
        end else if (bit_cnt == '0) begin
            val_sr  <= src_value;
            bcd_sr  <= '0;
            bit_cnt <= CW'(1);
        end else begin
            val_sr <= val_sr << 1;
            bcd_sr <= bcd_next;
            if (bit_cnt == CW'(DATA_WIDTH)) begin
                bit_cnt  <= '0;
                digits_q <= bcd_next;
            end else begin
                bit_cnt <= bit_cnt + CW'(1);
            end
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: seg7 = 7'b1000000;
            4'd1: seg7 = 7'b1111001;
            4'd2: seg7 = 7'b0100100;
            4'd3: seg7 = 7'b0110000;
            4'd4: seg7 = 7'b0011001;
            4'd5: seg7 = 7'b0010010;
            4'd6: seg7 = 7'b0000010;
            4'd7: seg7 = 7'b1111000;
            4'd8: seg7 = 7'b0000000;
            4'd9: seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

`ifdef RUN_MONITOR_BLANK_EN
    logic all_zero;
    always_comb begin
        seg      = '1;
        all_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero && (digits_q[4*i +: 4] == 4'd0);
            if (all_zero && i != 0) seg[7*i +: 7] = 7'b1111111;
            else                    seg[7*i +: 7] = seg7(digits_q[4*i +: 4]);
        end
    end
`else
    always_comb begin
        seg = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            seg[7*i +: 7] = seg7(digits_q[4*i +: 4]);
        end
    end
`endif

endmodule
